sd_cmd_sequencer: RTL and testbench
===================================

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 Parameter POLL_LIMIT, default 8, max response-poll byte reads before timeout (1..255).
REQ-002 Parameter ADDR_W, default 6, width of SPI controller byte address/size.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  host command request.
REQ-006 cmd_ready  output  1  sequencer idle, accepts command.
REQ-007 cmd_index  input  6  SD command number.
REQ-008 cmd_arg  input  32  command argument.
REQ-009 resp_valid  output  1  one-cycle pulse, response/timeout result available.
REQ-010 resp_r1  output  8  captured R1 byte (0xFF on timeout).
REQ-011 resp_timeout  output  1  qualifies resp_valid; set when no R1 within POLL_LIMIT.
REQ-012 cs_n  output  1  card chip select, active low.
REQ-013 spi_start  output  1  one-cycle start pulse to SPI controller.
REQ-014 spi_op  output  1  0 = read, 1 = write.
REQ-015 spi_size  output  ADDR_W  last byte index of transfer (bytes = size+1).
REQ-016 spi_address  input  ADDR_W  byte index requested/written by controller.
REQ-017 spi_tx_data  output  8  frame byte for spi_address (combinational).
REQ-018 spi_rx_data  input  8  received byte from controller.
REQ-019 spi_wr  input  1  received byte valid.
REQ-020 spi_done  input  1  one-cycle transfer-complete pulse.

Function
REQ-021 States SHALL be IDLE, LOAD, SEND, WAIT_TX, POLL, WAIT_RX, CHECK.
REQ-022 IDLE: cmd_ready=1; cmd_valid&&cmd_ready latches cmd_index/cmd_arg, clears poll count -> LOAD.
REQ-023 LOAD: build 6-byte frame: b0={2'b01,cmd_index}, b1..b4=cmd_arg MSB first, b5={crc7,1'b1}; -> SEND next cycle.
REQ-024 SEND: spi_start=1, spi_op=1, spi_size=5 for exactly one cycle -> WAIT_TX.
REQ-025 WAIT_TX: hold spi_op/spi_size; spi_done -> POLL.
REQ-026 POLL: spi_start=1, spi_op=0, spi_size=0 one cycle, poll count+1 -> WAIT_RX.
REQ-027 WAIT_RX: spi_wr captures spi_rx_data into rx register; spi_done -> CHECK (spi_wr and spi_done same cycle: capture taken).
REQ-028 CHECK: rx[7]==0 -> resp_r1=rx, resp_timeout=0, resp_valid pulse, -> IDLE.
REQ-029 CHECK: rx[7]==1 and count<POLL_LIMIT -> POLL; count==POLL_LIMIT -> resp_r1=0xFF, resp_timeout=1, resp_valid pulse, -> IDLE.
REQ-030 spi_tx_data = frame[spi_address] for address 0..5, 0xFF otherwise.
REQ-031 cs_n=0 in every state except IDLE; cs_n=1 in IDLE.
REQ-032 Command-to-first-spi_start latency SHALL be 2 cycles (accept, LOAD, SEND).
REQ-033 cmd_valid while cmd_ready=0 SHALL be ignored, no queueing.
REQ-034 spi_done outside WAIT_TX/WAIT_RX and spi_wr outside WAIT_RX SHALL be ignored.
REQ-035 resp_r1/resp_timeout SHALL hold their value until next resp_valid.
REQ-036 Poll counter 8 bits, saturating; never wraps.

Reset
REQ-037 rst_n low SHALL immediately force IDLE, cs_n=1, spi_start=0, spi_op=0, spi_size=0, resp_valid=0, resp_timeout=0, resp_r1=0xFF, frame bytes 0xFF, poll count 0.
REQ-038 Reset mid-transfer SHALL abandon it; no resp_valid is produced for the aborted command.

Configuration
REQ-039 Macro SD_CMD_CRC7_EN defined: crc7 = CRC7 (poly x^7+x^3+1, init 0) over b0..b4, computed in LOAD.
REQ-040 Macro undefined: crc7 = 7'h4A for cmd_index 0, 7'h43 for cmd_index 8, 7'h00 otherwise; LOAD timing unchanged.

Verification
REQ-041 CMD0 arg 0 -> spi_tx_data bytes 0x40,00,00,00,00,0x95; spi_size=5, spi_op=1.
REQ-042 CMD8 arg 0x000001AA -> bytes 0x48,00,00,01,0xAA,0x87 (both macro settings).
REQ-043 After TX, rx sequence 0xFF,0xFF,0x01 -> three polls, resp_valid with resp_r1=0x01, resp_timeout=0.
REQ-044 rx always 0xFF, POLL_LIMIT=8 -> exactly 8 read starts, resp_valid, resp_r1=0xFF, resp_timeout=1.
REQ-045 rst_n asserted in WAIT_RX -> cs_n=1, cmd_ready=1 next cycle, no resp_valid.
REQ-046 SD_CMD_CRC7_EN defined, CMD17 arg 0 -> b5=0x55; cmd_valid during busy ignored.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: frames a 6-byte command, sends it through
// an external SPI byte controller, then polls single bytes until an R1 response
// (bit7 clear) arrives or the poll budget is exhausted.
// Optional macro SD_CMD_CRC7_EN: compute the real CRC7 over the frame instead of
// using the fixed CMD0/CMD8 constants.
module sd_cmd_sequencer #(
  parameter int unsigned POLL_LIMIT = 8,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_index,
  input  logic [31:0]       cmd_arg,
  output logic              resp_valid,
  output logic [7:0]        resp_r1,
  output logic              resp_timeout,
  output logic              cs_n,
  output logic              spi_start,
  output logic              spi_op,
  output logic [ADDR_W-1:0] spi_size,
  input  logic [ADDR_W-1:0] spi_address,
  output logic [7:0]        spi_tx_data,
  input  logic [7:0]        spi_rx_data,
  input  logic              spi_wr,
  input  logic              spi_done
);

  localparam int unsigned FRAME_BYTES = 6;
  localparam logic [ADDR_W-1:0] CMD_LAST = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_TX, POLL, WAIT_RX, CHECK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [5:0]            r_cmd_index;
  logic [31:0]           r_cmd_arg;
  logic [FRAME_BYTES-1:0][7:0] r_frame;
  logic [7:0]            r_rx;
  logic [7:0]            r_poll_cnt;
  logic                  r_resp_valid;
  logic [7:0]            r_resp_r1;
  logic                  r_resp_timeout;
  logic                  r_cmd_ready;
  logic                  r_cs_n;
  logic                  r_spi_start;
  logic                  r_spi_op;
  logic [ADDR_W-1:0]     r_spi_size;

  logic                  w_accept;
  logic                  w_build;
  logic                  w_poll_inc;
  logic                  w_rx_cap;
  logic                  w_resp_fire;
  logic                  w_resp_to;
  logic [7:0]            w_b0;
  logic [6:0]            w_crc7;

`ifdef SD_CMD_CRC7_EN
  // Bitwise CRC7 (x^7+x^3+1, init 0) over the first five frame bytes, MSB first
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction
`endif

  assign w_b0 = {2'b01, r_cmd_index};

  // CRC field of the last frame byte
  always_comb begin
`ifdef SD_CMD_CRC7_EN
    w_crc7 = crc7_calc({w_b0, r_cmd_arg});
`else
    w_crc7 = 7'h00;
    if (r_cmd_index == 6'd0)      w_crc7 = 7'h4A;
    else if (r_cmd_index == 6'd8) w_crc7 = 7'h43;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_build     = 1'b0;
    w_poll_inc  = 1'b0;
    w_rx_cap    = 1'b0;
    w_resp_fire = 1'b0;
    w_resp_to   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_build     = 1'b1;
        w_state_nxt = SEND;
      end
      SEND:    w_state_nxt = WAIT_TX;
      WAIT_TX: if (spi_done) w_state_nxt = POLL;
      POLL: begin
        w_poll_inc  = 1'b1;
        w_state_nxt = WAIT_RX;
      end
      WAIT_RX: begin
        w_rx_cap = spi_wr;
        if (spi_done) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (!r_rx[7]) begin
          w_resp_fire = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_poll_cnt >= POLL_MAX) begin
          w_resp_fire = 1'b1;
          w_resp_to   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = POLL;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command latch, frame build, poll counter and rx capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_frame     <= {FRAME_BYTES{8'hFF}};
      r_rx        <= 8'hFF;
      r_poll_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_cmd_index <= cmd_index;
        r_cmd_arg   <= cmd_arg;
        r_poll_cnt  <= '0;
      end
      if (w_build) begin
        r_frame[0] <= w_b0;
        r_frame[1] <= r_cmd_arg[31:24];
        r_frame[2] <= r_cmd_arg[23:16];
        r_frame[3] <= r_cmd_arg[15:8];
        r_frame[4] <= r_cmd_arg[7:0];
        r_frame[5] <= {w_crc7, 1'b1};
      end
      if (w_poll_inc && (r_poll_cnt != 8'hFF)) r_poll_cnt <= r_poll_cnt + 8'd1;
      if (w_rx_cap) r_rx <= spi_rx_data;
    end
  end

  // Registered outputs, decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready    <= 1'b1;
      r_cs_n         <= 1'b1;
      r_spi_start    <= 1'b0;
      r_spi_op       <= 1'b0;
      r_spi_size     <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_r1      <= 8'hFF;
      r_resp_timeout <= 1'b0;
    end else begin
      r_cmd_ready  <= (w_state_nxt == IDLE);
      r_cs_n       <= (w_state_nxt == IDLE);
      r_spi_start  <= (w_state_nxt == SEND) || (w_state_nxt == POLL);
      r_spi_op     <= (w_state_nxt == SEND) || (w_state_nxt == WAIT_TX);
      r_spi_size   <= ((w_state_nxt == SEND) || (w_state_nxt == WAIT_TX)) ? CMD_LAST : '0;
      r_resp_valid <= w_resp_fire;
      if (w_resp_fire) begin
        r_resp_r1      <= w_resp_to ? 8'hFF : r_rx;
        r_resp_timeout <= w_resp_to;
      end
    end
  end

  // Frame byte lookup for the SPI controller
  always_comb begin
    spi_tx_data = 8'hFF;
    if (spi_address < ADDR_W'(FRAME_BYTES)) spi_tx_data = r_frame[3'(spi_address)];
  end

  assign cmd_ready    = r_cmd_ready;
  assign cs_n         = r_cs_n;
  assign spi_start    = r_spi_start;
  assign spi_op       = r_spi_op;
  assign spi_size     = r_spi_size;
  assign resp_valid   = r_resp_valid;
  assign resp_r1      = r_resp_r1;
  assign resp_timeout = r_resp_timeout;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: acts as the SPI byte controller and
// compares against a frame/response model built from the command rules.
module tb_sd_cmd_sequencer;

  localparam int unsigned POLL_LIMIT = 8;
  localparam int unsigned ADDR_W     = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_arg;
  logic              resp_valid;
  logic [7:0]        resp_r1;
  logic              resp_timeout;
  logic              cs_n;
  logic              spi_start;
  logic              spi_op;
  logic [ADDR_W-1:0] spi_size;
  logic [ADDR_W-1:0] spi_address;
  logic [7:0]        spi_tx_data;
  logic [7:0]        spi_rx_data;
  logic              spi_wr;
  logic              spi_done;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_r1 = 8'hFF;
  logic       prev_to = 1'b0;

  sd_cmd_sequencer #(.POLL_LIMIT(POLL_LIMIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_timeout(resp_timeout),
    .cs_n(cs_n), .spi_start(spi_start), .spi_op(spi_op), .spi_size(spi_size),
    .spi_address(spi_address), .spi_tx_data(spi_tx_data),
    .spi_rx_data(spi_rx_data), .spi_wr(spi_wr), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of message*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [5:0] idx, input logic [31:0] arg, input int k);
    logic [7:0] b0;
    logic [6:0] crc;
    b0 = {2'b01, idx};
`ifdef SD_CMD_CRC7_EN
    crc = ref_crc7({b0, arg});
`else
    crc = (idx == 6'd0) ? 7'h4A : (idx == 6'd8) ? 7'h43 : 7'h00;
`endif
    case (k)
      0: return b0;
      1: return arg[31:24];
      2: return arg[23:16];
      3: return arg[15:8];
      4: return arg[7:0];
      5: return {crc, 1'b1};
      default: return 8'hFF;
    endcase
  endfunction

  // Accept a command, check the start latency and walk the transmit frame
  task automatic issue_and_tx(input logic [5:0] idx, input logic [31:0] arg);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("load_start", 32'(spi_start), 32'd0);
    check("load_csn", 32'(cs_n), 32'd0);
    check("load_ready", 32'(cmd_ready), 32'd0);
    cmd_index = ~idx;
    cmd_arg   = ~arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("send_start", 32'(spi_start), 32'd1);
    check("send_op", 32'(spi_op), 32'd1);
    check("send_size", 32'(spi_size), 32'd5);
    check("r1_hold", 32'(resp_r1), 32'(prev_r1));
    check("to_hold", 32'(resp_timeout), 32'(prev_to));
    @(negedge clk);
    check("wtx_start", 32'(spi_start), 32'd0);
    check("wtx_op", 32'(spi_op), 32'd1);
    check("wtx_size", 32'(spi_size), 32'd5);
    for (int a = 0; a < 8; a++) begin
      spi_address = ADDR_W'(a);
      #1;
      check($sformatf("tx_b%0d_cmd%0d", a, idx), 32'(spi_tx_data), 32'(ref_byte(idx, arg, a)));
      @(negedge clk);
    end
    spi_address = '0;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
  endtask

  // Serve one single-byte read from WAIT_RX
  task automatic serve_read(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    spi_rx_data = b;
    spi_wr      = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      spi_done = 1'b1;
      @(negedge clk);
      spi_wr   = 1'b0;
      spi_done = 1'b0;
    end else begin
      @(negedge clk);
      spi_wr      = 1'b0;
      spi_rx_data = b ^ 8'h80;
      spi_done    = 1'b1;
      @(negedge clk);
      spi_done    = 1'b0;
    end
  endtask

  // Full command: n_ff busy bytes precede r1
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int n_ff, input logic [7:0] r1);
    int starts, guard, rv, exp_polls;
    logic [7:0] got_r1, exp_r1;
    logic got_to, exp_to;
    exp_to    = (n_ff >= int'(POLL_LIMIT));
    exp_polls = exp_to ? int'(POLL_LIMIT) : n_ff + 1;
    exp_r1    = exp_to ? 8'hFF : r1;
    issue_and_tx(idx, arg);
    starts = 0; guard = 0; rv = 0;
    got_r1 = 8'h00; got_to = 1'b0;
    while (rv == 0 && guard < 200) begin
      if (spi_start) begin
        starts++;
        check("poll_op", 32'(spi_op), 32'd0);
        check("poll_size", 32'(spi_size), 32'd0);
        @(negedge clk);
        serve_read((starts <= n_ff) ? 8'hFF : r1);
      end else if (resp_valid) begin
        rv = 1;
        got_r1 = resp_r1;
        got_to = resp_timeout;
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    check("resp_seen", 32'(rv), 32'd1);
    check("poll_count", 32'(starts), 32'(exp_polls));
    check("resp_r1", 32'(got_r1), 32'(exp_r1));
    check("resp_timeout", 32'(got_to), 32'(exp_to));
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("idle_csn", 32'(cs_n), 32'd1);
    check("r1_after", 32'(resp_r1), 32'(exp_r1));
    prev_r1 = exp_r1;
    prev_to = exp_to;
  endtask

  // Reset while waiting for a poll byte
  task automatic reset_in_wait_rx();
    int seen;
    issue_and_tx(6'd17, 32'h0000_1000);
    check("rst_poll_start", 32'(spi_start), 32'd1);
    @(negedge clk);
    spi_wr = 1'b1;
    spi_rx_data = 8'h00;
    rst_n = 1'b0;
    #1;
    check("rst_csn", 32'(cs_n), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_r1", 32'(resp_r1), 32'hFF);
    check("rst_frame", 32'(spi_tx_data), 32'hFF);
    @(negedge clk);
    spi_wr = 1'b0;
    spi_done = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("rst_no_resp", 32'(seen), 32'd0);
    check("rst_idle_csn", 32'(cs_n), 32'd1);
    prev_r1 = 8'hFF;
    prev_to = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0;
    spi_address = '0; spi_rx_data = 8'hFF; spi_wr = 1'b0; spi_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_csn", 32'(cs_n), 32'd1);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_start", 32'(spi_start), 32'd0);
    check("reset_op", 32'(spi_op), 32'd0);
    check("reset_size", 32'(spi_size), 32'd0);
    check("reset_valid", 32'(resp_valid), 32'd0);
    check("reset_to", 32'(resp_timeout), 32'd0);
    check("reset_r1", 32'(resp_r1), 32'hFF);
    check("reset_frame", 32'(spi_tx_data), 32'hFF);
    rst_n = 1'b1;
    // stray controller strobes while idle
    spi_done = 1'b1; spi_wr = 1'b1; spi_rx_data = 8'h00;
    @(negedge clk);
    spi_done = 1'b0; spi_wr = 1'b0; spi_rx_data = 8'hFF;
    check("idle_stray_valid", 32'(resp_valid), 32'd0);
    check("idle_stray_ready", 32'(cmd_ready), 32'd1);

    do_cmd(6'd0, 32'h0, 0, 8'h01);
    do_cmd(6'd8, 32'h0000_01AA, 2, 8'h01);
    do_cmd(6'd17, 32'h0, int'(POLL_LIMIT), 8'h00);
    do_cmd(6'd55, 32'hDEAD_BEEF, int'(POLL_LIMIT) - 1, 8'h05);
    do_cmd(6'd24, 32'h1234_5678, int'(POLL_LIMIT) + 3, 8'h00);
    reset_in_wait_rx();
    for (int n = 0; n < 20; n++)
      do_cmd(6'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, POLL_LIMIT + 1)),
             8'($urandom_range(0, 127)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
